// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_LO = 3'd1,
    CNT_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  // Error codes reported on err
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  // Default frame start byte
  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

endpackage

// File: rtl/imem_word_assembler.sv
// Collects little-endian data bytes into 32-bit words and keeps a running
// XOR of every data byte. The full word is presented combinationally in the
// cycle its last byte is accepted, so the parent can register it directly.
module imem_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_done,
  output logic [31:0] word,
  output logic [7:0]  csum
);

  logic [1:0]  lane_q;
  logic [23:0] lo_q;
  logic [7:0]  csum_q;

  assign word_done = byte_en && (lane_q == 2'd3);
  assign word      = {byte_in, lo_q};
  assign csum      = csum_q;

  // Lane counter, lower three byte lanes and running checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= 2'd0;
      lo_q   <= 24'd0;
      csum_q <= 8'd0;
    end else if (clr) begin
      lane_q <= 2'd0;
      lo_q   <= 24'd0;
      csum_q <= 8'd0;
    end else if (byte_en) begin
      lane_q <= lane_q + 2'd1;
      csum_q <= csum_q ^ byte_in;
      case (lane_q)
        2'd0:    lo_q[7:0]   <= byte_in;
        2'd1:    lo_q[15:8]  <= byte_in;
        2'd2:    lo_q[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a framed byte stream, writes words into the
// instruction memory and releases the CPU only after a verified image.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready;
// in_ready depends only on the FSM state, never on in_valid. clear has
// priority and the byte offered alongside it is dropped.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [7:0]  MAGIC     = DEFAULT_MAGIC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        clear,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic [1:0]  err
);

  localparam int IW = $clog2(DEPTH) + 1;

  state_t        state, state_nxt;
  logic [15:0]   count_q;
  logic [IW-1:0] index_q;
  logic [1:0]    err_q;
  logic          accepting;
  logic          xfer;
  logic [15:0]   cnt_word;
  logic          cnt_ovf;
  logic          last_word;
  logic          asm_clr;
  logic          asm_en;
  logic          word_done;
  logic [31:0]   word;
  logic [7:0]    csum;

  assign accepting = (state != DONE) && (state != ERR);
  assign in_ready  = accepting;
  assign xfer      = in_valid && accepting && !clear;
  assign cnt_word  = {in_data, count_q[7:0]};
  assign cnt_ovf   = cnt_word > 16'(DEPTH);
  assign last_word = (16'(index_q) + 16'd1) == count_q;
  assign asm_clr   = clear || (xfer && (state == IDLE) && (in_data == MAGIC));
  assign asm_en    = xfer && (state == DATA);
  assign err       = err_q;

  imem_word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (asm_clr),
    .byte_en   (asm_en),
    .byte_in   (in_data),
    .word_done (word_done),
    .word      (word),
    .csum      (csum)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and state-derived status outputs
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    cpu_hold  = 1'b1;
    if (state == DONE) begin
      done     = 1'b1;
      cpu_hold = 1'b0;
    end
    if (clear) begin
      state_nxt = IDLE;
    end else if (xfer) begin
      case (state)
        IDLE:    if (in_data == MAGIC) state_nxt = CNT_LO;
        CNT_LO:  state_nxt = CNT_HI;
        CNT_HI: begin
          if (cnt_ovf)               state_nxt = ERR;
          else if (cnt_word == 16'd0) state_nxt = CSUM;
          else                        state_nxt = DATA;
        end
        DATA:    if (word_done && last_word) state_nxt = CSUM;
        CSUM:    state_nxt = (in_data == csum) ? DONE : ERR;
        default: ;
      endcase
    end
  end

  // Count/index tracking, write port and latched error code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 16'd0;
      index_q   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= 32'd0;
      err_q     <= ERR_NONE;
    end else begin
      mem_we <= 1'b0;
      if (clear) begin
        err_q <= ERR_NONE;
      end else if (xfer) begin
        case (state)
          IDLE: begin
            if (in_data == MAGIC) begin
              count_q <= 16'd0;
              index_q <= '0;
            end
          end
          CNT_LO: count_q[7:0] <= in_data;
          CNT_HI: begin
            count_q[15:8] <= in_data;
            if (cnt_ovf) err_q <= ERR_OVF;
          end
          DATA: begin
            if (word_done) begin
              mem_we    <= 1'b1;
              mem_addr  <= BASE_ADDR + (32'(index_q) << 2);
              mem_wdata <= word;
              index_q   <= index_q + IW'(1);
            end
          end
          CSUM: if (in_data != csum) err_q <= ERR_CSUM;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of whole frames with expected end status and
// expected memory writes, plus hand-written clear, full-rate and reset runs.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        clear;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic [1:0]  err;

  int checks   = 0;
  int failures = 0;

  // Expected writes as {addr, data}
  logic [63:0] exp_q[$];
  logic        prev_we = 1'b0;

  typedef struct {
    string        name;
    logic [127:0] bytes;   // right-aligned, first byte most significant
    int           n;
    int           nw;
    logic [31:0]  a0, d0, a1, d1;
    logic         exp_done;
    logic [1:0]   exp_err;
    logic         exp_ready;
    logic         exp_hold;
  } vec_t;

  vec_t vt[6];

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clear     (clear),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every write pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      chk("we_single_cycle", 32'(prev_we), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=%h data=%h expected no write", mem_addr, mem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e[63:32]);
        chk("wr_data", mem_wdata, e[31:0]);
      end
    end
    prev_we = mem_we;
  end

  // Driver tasks: inputs change on the falling edge, DUT samples on the rising edge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(0, 255));
      @(posedge clk);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic r, input logic h,
                              input logic d, input logic [1:0] e);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(r));
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
    chk({tag, "_done"},     32'(done),     32'(d));
    chk({tag, "_err"},      32'(err),      32'(e));
  endtask

  function automatic vec_t mk(input string nm, input logic [127:0] by, input int n,
                              input int nw, input logic [31:0] a0, input logic [31:0] d0,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic dn, input logic [1:0] er,
                              input logic rdy, input logic hold);
    vec_t v;
    v.name = nm; v.bytes = by; v.n = n; v.nw = nw;
    v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.exp_done = dn; v.exp_err = er; v.exp_ready = rdy; v.exp_hold = hold;
    return v;
  endfunction

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clear    = 1'b0;

    // Checksum of 13 00 00 00 93 00 10 00 is 13^93^10 = 90
    vt[0] = mk("good2", 128'hA5_02_00_13_00_00_00_93_00_10_00_90, 12, 2,
               32'h0, 32'h0000_0013, 32'h4, 32'h0010_0093, 1'b1, 2'b00, 1'b0, 1'b0);
    vt[1] = mk("badcsum", 128'hA5_02_00_13_00_00_00_93_00_10_00_81, 12, 2,
               32'h0, 32'h0000_0013, 32'h4, 32'h0010_0093, 1'b0, 2'b10, 1'b0, 1'b1);
    vt[2] = mk("ovf129", 128'hA5_81_00, 3, 0,
               32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b01, 1'b0, 1'b1);
    vt[3] = mk("ovf256", 128'hA5_00_01, 3, 0,
               32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b01, 1'b0, 1'b1);
    vt[4] = mk("garbage_cnt0", 128'h00_FF_5A_A5_00_00_00, 7, 0,
               32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0);
    // EF^BE^AD^DE = 22
    vt[5] = mk("one_word", 128'hA5_01_00_EF_BE_AD_DE_22, 8, 1,
               32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0);

    // Reset state
    #12;
    chk("rst_in_ready",  32'(in_ready), 32'd1);
    chk("rst_mem_we",    32'(mem_we),   32'd0);
    chk("rst_mem_addr",  mem_addr,      32'h0);
    chk("rst_mem_wdata", mem_wdata,     32'h0);
    chk("rst_cpu_hold",  32'(cpu_hold), 32'd1);
    chk("rst_done",      32'(done),     32'd0);
    chk("rst_err",       32'(err),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      pulse_clear();
      check_status({vt[v].name, "_postclear"}, 1'b1, 1'b1, 1'b0, 2'b00);
      if (vt[v].nw > 0) exp_q.push_back({vt[v].a0, vt[v].d0});
      if (vt[v].nw > 1) exp_q.push_back({vt[v].a1, vt[v].d1});
      for (int i = 0; i < vt[v].n; i++) begin
        send_byte(vt[v].bytes[8*(vt[v].n-1-i) +: 8]);
        idle($urandom_range(0, 2));
      end
      idle(2);
      chk({vt[v].name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
      check_status(vt[v].name, vt[v].exp_ready, vt[v].exp_hold, vt[v].exp_done, vt[v].exp_err);
      // Offered bytes while not ready must change nothing
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (2) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      idle(1);
      check_status({vt[v].name, "_held"}, vt[v].exp_ready, vt[v].exp_hold, vt[v].exp_done, vt[v].exp_err);
    end

    // clear after the second byte of word 1 in a 3-word frame
    pulse_clear();
    exp_q.push_back({32'h0, 32'h4433_2211});
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(posedge clk);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    idle(2);
    chk("clr_writes_left", 32'(exp_q.size()), 32'd0);
    check_status("clr", 1'b1, 1'b1, 1'b0, 2'b00);
    // Fresh frame restarts at BASE_ADDR; 78^56^34^12 = 08
    exp_q.push_back({32'h0, 32'h1234_5678});
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h08);
    idle(2);
    chk("fresh_writes_left", 32'(exp_q.size()), 32'd0);
    check_status("fresh", 1'b0, 1'b0, 1'b1, 2'b00);

    // Full-rate 128-word image; data byte j = j, checksum of 0..511 bytes = 00
    pulse_clear();
    for (int i = 0; i < 128; i++)
      exp_q.push_back({32'(4*i), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    send_byte(8'hA5); send_byte(8'h80); send_byte(8'h00);
    for (int j = 0; j < 512; j++) send_byte(8'(j));
    send_byte(8'h00);
    idle(2);
    chk("full_writes_left", 32'(exp_q.size()), 32'd0);
    chk("full_last_addr", mem_addr, 32'h0000_01FC);
    check_status("full", 1'b0, 1'b0, 1'b1, 2'b00);

    // Reset mid-stream: 12 complete words, then reset while valid is held
    pulse_clear();
    for (int i = 0; i < 12; i++)
      exp_q.push_back({32'(4*i), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    send_byte(8'hA5); send_byte(8'h80); send_byte(8'h00);
    for (int j = 0; j < 50; j++) send_byte(8'(j));
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd50;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  32'(in_ready), 32'd1);
    chk("mid_rst_mem_we",    32'(mem_we),   32'd0);
    chk("mid_rst_mem_addr",  mem_addr,      32'h0);
    chk("mid_rst_mem_wdata", mem_wdata,     32'h0);
    chk("mid_rst_cpu_hold",  32'(cpu_hold), 32'd1);
    chk("mid_rst_done",      32'(done),     32'd0);
    chk("mid_rst_err",       32'(err),      32'd0);
    chk("mid_rst_writes_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    idle(2);
    check_status("after_rst", 1'b1, 1'b1, 1'b0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
